alu_input_ctrl: RTL and testbench

Upstream operand/command stage for the combinational ALU. It debounces the board push-buttons and walks the user through a fixed entry sequence: load A, load B, execute. It then presents stable, registered a, b, op, op_sum and op_subt to the ALU. The ALU itself stays purely combinational; every user-facing timing concern lives here.

---
 rtl/alu_input_ctrl.sv | 133 +++++++++++++
 tb/tb_alu_input_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_input_ctrl.sv
// Operand/command entry stage for the combinational ALU: synchronises and debounces
// the load/exec buttons, then walks A -> B -> execute and holds registered ALU inputs.
module alu_input_ctrl #(
    parameter int N               = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic [2:0]   op_sw,
    input  logic         sum_sw,
    input  logic         subt_sw,
    input  logic         btn_load_n,
    input  logic         btn_exec_n,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [2:0]   op,
    output logic         op_sum,
    output logic         op_subt,
    output logic         valid,
    output logic [1:0]   state
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        HOLD    = 2'd3
    } fsm_t;

    // Index 0 is the load button, index 1 the exec button.
    logic [1:0]    btn_n;
    logic [1:0]    sync0;
    logic [1:0]    sync1;
    logic [1:0]    deb;
    logic [1:0]    armed;
    logic [1:0]    press;
    logic [1:0]    warm;
    logic [CW-1:0] cnt [2];

    assign btn_n = {btn_exec_n, btn_load_n};

    // A button may only raise events once it has been seen released after reset, so a
    // button held through reset is debounced silently and must be re-pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // pre-edge values regardless of statement order.
            sync0 <= '1;
            sync1 <= '1;
            deb   <= '1;
            armed <= '0;
            press <= '0;
            warm  <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync0 <= btn_n;
            sync1 <= sync0;
            warm  <= {warm[0], 1'b1};
            for (int i = 0; i < 2; i++) begin
                press[i] <= 1'b0;
                if (sync1[i] != deb[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        deb[i]   <= sync1[i];
                        cnt[i]   <= '0;
                        press[i] <= armed[i] & ~sync1[i];
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
                if (warm[1] && sync1[i] && deb[i]) armed[i] <= 1'b1;
            end
        end
    end

    logic load_ev;
    logic exec_ev;
    fsm_t st;

    assign load_ev = press[0];
    assign exec_ev = press[1];
    assign state   = st;

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= WAIT_A;
            a       <= '0;
            b       <= '0;
            op      <= 3'b111;
            op_sum  <= 1'b0;
            op_subt <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (st)
                WAIT_A: if (load_ev) begin
                    a  <= sw;
                    st <= WAIT_B;
                end
                WAIT_B: if (load_ev) begin
                    b  <= sw;
                    st <= WAIT_OP;
                end
                WAIT_OP: if (exec_ev) begin
                    op      <= op_sw;
                    op_subt <= subt_sw;
                    op_sum  <= sum_sw & ~subt_sw;
                    valid   <= 1'b1;
                    st      <= HOLD;
                end
                HOLD: begin
                    // Load takes precedence over a coincident exec.
                    if (load_ev) begin
                        a  <= sw;
                        st <= WAIT_B;
                    end else if (exec_ev) begin
                        op      <= op_sw;
                        op_subt <= subt_sw;
                        op_sum  <= sum_sw & ~subt_sw;
                        valid   <= 1'b1;
                    end
                end
                default: st <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Directed bench for alu_input_ctrl with DEBOUNCE_CYCLES = 4: a vector table for the
// entry sequence plus hand-written bounce, hold, simultaneous-press and reset cases.
module tb_alu_input_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw;
    logic [2:0]   op_sw;
    logic         sum_sw;
    logic         subt_sw;
    logic         btn_load_n;
    logic         btn_exec_n;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         op_sum;
    logic         op_subt;
    logic         valid;
    logic [1:0]   state;

    int total = 0;
    int bad   = 0;
    int valid_hi = 0;

    alu_input_ctrl #(.N(N), .DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .op_sw      (op_sw),
        .sum_sw     (sum_sw),
        .subt_sw    (subt_sw),
        .btn_load_n (btn_load_n),
        .btn_exec_n (btn_exec_n),
        .a          (a),
        .b          (b),
        .op         (op),
        .op_sum     (op_sum),
        .op_subt    (op_subt),
        .valid      (valid),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Counts cycles with valid high, so a pulse wider than one cycle shows up.
    always @(negedge clk) if (valid === 1'b1) valid_hi++;

    typedef struct {
        logic         is_exec;
        logic [N-1:0] sw;
        logic [2:0]   op_sw;
        logic         sum_sw;
        logic         subt_sw;
        logic [N-1:0] exp_a;
        logic [N-1:0] exp_b;
        logic [2:0]   exp_op;
        logic         exp_sum;
        logic         exp_subt;
        logic [1:0]   exp_state;
        int           exp_pulses;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press long enough to pass sync + debounce, then release long enough to settle.
    task automatic press(input logic is_exec);
        if (is_exec) btn_exec_n = 1'b0; else btn_load_n = 1'b0;
        cycles(12);
        if (is_exec) btn_exec_n = 1'b1; else btn_load_n = 1'b1;
        cycles(12);
    endtask

    task automatic check_outs(input string tag, input logic [N-1:0] ea, input logic [N-1:0] eb,
                              input logic [2:0] eop, input logic es, input logic et,
                              input logic [1:0] est);
        check({tag, ".a"},       32'(a),       32'(ea));
        check({tag, ".b"},       32'(b),       32'(eb));
        check({tag, ".op"},      32'(op),      32'(eop));
        check({tag, ".op_sum"},  32'(op_sum),  32'(es));
        check({tag, ".op_subt"}, 32'(op_subt), 32'(et));
        check({tag, ".state"},   32'(state),   32'(est));
    endtask

    initial begin
        int v0;

        //          exec sw     op_sw   sum   subt  a      b      op      s     t     st     pulses
        vecs[0] = '{1'b0, 4'hF, 3'b000, 1'b0, 1'b0, 4'hF, 4'h0, 3'b111, 1'b0, 1'b0, 2'd1, 0};
        vecs[1] = '{1'b1, 4'h0, 3'b000, 1'b1, 1'b0, 4'hF, 4'h0, 3'b111, 1'b0, 1'b0, 2'd1, 0};
        vecs[2] = '{1'b0, 4'h8, 3'b000, 1'b0, 1'b0, 4'hF, 4'h8, 3'b111, 1'b0, 1'b0, 2'd2, 0};
        vecs[3] = '{1'b0, 4'h3, 3'b000, 1'b0, 1'b0, 4'hF, 4'h8, 3'b111, 1'b0, 1'b0, 2'd2, 0};
        vecs[4] = '{1'b1, 4'h0, 3'b111, 1'b1, 1'b0, 4'hF, 4'h8, 3'b111, 1'b1, 1'b0, 2'd3, 1};
        vecs[5] = '{1'b1, 4'h0, 3'b010, 1'b1, 1'b1, 4'hF, 4'h8, 3'b010, 1'b0, 1'b1, 2'd3, 1};
        vecs[6] = '{1'b1, 4'h0, 3'b000, 1'b0, 1'b0, 4'hF, 4'h8, 3'b000, 1'b0, 1'b0, 2'd3, 1};
        vecs[7] = '{1'b0, 4'h3, 3'b110, 1'b1, 1'b1, 4'h3, 4'h8, 3'b000, 1'b0, 1'b0, 2'd1, 0};
        vecs[8] = '{1'b0, 4'h5, 3'b110, 1'b1, 1'b1, 4'h3, 4'h5, 3'b000, 1'b0, 1'b0, 2'd2, 0};
        vecs[9] = '{1'b1, 4'h0, 3'b101, 1'b0, 1'b1, 4'h3, 4'h5, 3'b101, 1'b0, 1'b1, 2'd3, 1};

        rst = 1'b1; sw = '0; op_sw = 3'b000; sum_sw = 1'b0; subt_sw = 1'b0;
        btn_load_n = 1'b1; btn_exec_n = 1'b1;
        cycles(2);
        check_outs("reset", 4'h0, 4'h0, 3'b111, 1'b0, 1'b0, 2'd0);
        check("reset.valid", 32'(valid), 32'd0);
        rst = 1'b0;
        cycles(4);

        for (int i = 0; i < 10; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            sw = vecs[i].sw; op_sw = vecs[i].op_sw;
            sum_sw = vecs[i].sum_sw; subt_sw = vecs[i].subt_sw;
            v0 = valid_hi;
            press(vecs[i].is_exec);
            check_outs(tag, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_op,
                       vecs[i].exp_sum, vecs[i].exp_subt, vecs[i].exp_state);
            check({tag, ".valid_cycles"}, 32'(valid_hi - v0), 32'(vecs[i].exp_pulses));
        end

        // Bounce: 2-cycle low/high runs never survive the 4-cycle debounce.
        sw = 4'hE;
        v0 = valid_hi;
        for (int i = 0; i < 10; i++) begin
            btn_load_n = i[0];
            cycles(2);
        end
        btn_load_n = 1'b1;
        cycles(20);
        check("bounce.a", 32'(a), 32'h3);
        check("bounce.state", 32'(state), 32'd3);
        check("bounce.valid_cycles", 32'(valid_hi - v0), 32'd0);

        // Held exec in WAIT_OP: one event only.
        sw = 4'h6; press(1'b0);
        sw = 4'h9; press(1'b0);
        check("held.pre_state", 32'(state), 32'd2);
        op_sw = 3'b011; sum_sw = 1'b1; subt_sw = 1'b0;
        v0 = valid_hi;
        btn_exec_n = 1'b0;
        cycles(50);
        btn_exec_n = 1'b1;
        cycles(15);
        check("held.valid_cycles", 32'(valid_hi - v0), 32'd1);
        check_outs("held", 4'h6, 4'h9, 3'b011, 1'b1, 1'b0, 2'd3);

        // Simultaneous load and exec in HOLD: load wins, no valid.
        sw = 4'hA; op_sw = 3'b001; sum_sw = 1'b0; subt_sw = 1'b1;
        v0 = valid_hi;
        btn_load_n = 1'b0; btn_exec_n = 1'b0;
        cycles(12);
        btn_load_n = 1'b1; btn_exec_n = 1'b1;
        cycles(12);
        check_outs("simul", 4'hA, 4'h9, 3'b011, 1'b1, 1'b0, 2'd1);
        check("simul.valid_cycles", 32'(valid_hi - v0), 32'd0);

        // Reset in WAIT_B with load held through reset release.
        sw = 4'hF;
        btn_load_n = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(2);
        check_outs("midrst", 4'h0, 4'h0, 3'b111, 1'b0, 1'b0, 2'd0);
        rst = 1'b0;
        cycles(20);
        check("midrst.held_a", 32'(a), 32'h0);
        check("midrst.held_state", 32'(state), 32'd0);
        btn_load_n = 1'b1;
        cycles(15);
        check("midrst.release_state", 32'(state), 32'd0);
        sw = 4'h7;
        press(1'b0);
        check("midrst.repress_a", 32'(a), 32'h7);
        check("midrst.repress_state", 32'(state), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
